// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings for the two-master memory bus arbiter
package mem_bus_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;
   localparam logic M_CPU = 1'b0;
   localparam logic M_LOADER = 1'b1;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   function automatic logic misaligned(input logic [1:0] a);
      return |(a & ALIGN_MASK);
   endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: two-way round-robin picker, locked owner wins or reserves the bus
module rr_select
   import mem_bus_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       lock_i,
   input  logic       owner_i,
   input  logic       upd_i,
   output logic       valid_o,
   output logic       gnt_o
);
   logic rr_last_q, rr_last_d;
   always_comb begin
      rr_last_d = upd_i ? owner_i : rr_last_q;
      valid_o = lock_i ? req_i[owner_i] : |req_i;
      gnt_o = lock_i ? owner_i : (&req_i ? ~rr_last_q : req_i[M_LOADER]);
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) rr_last_q <= M_LOADER;
      else rr_last_q <= rr_last_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one word-wide synchronous memory bus between CPU (M0) and loader (M1)
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic              m0_we_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   input  logic              m0_lock_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic              m1_we_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   input  logic              m1_lock_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              owner_o
);
   state_e state_q, state_d;
   logic owner_q, owner_d, we_q, we_d, gnt_valid, gnt, mis;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0] ack_q, ack_d, err_q, err_d;
   logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

   assign mis = misaligned(addr_q[1:0]);

   rr_select u_rr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   ({m1_req_i, m0_req_i}),
      .lock_i  (owner_q ? m1_lock_i : m0_lock_i),
      .owner_i (owner_q),
      .upd_i   (state_q == RESP),
      .valid_o (gnt_valid),
      .gnt_o   (gnt)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      addr_d = addr_q;
      we_d = we_q;
      wdata_d = wdata_q;
      ack_d = '0;
      err_d = '0;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (gnt_valid) begin
            state_d = ISSUE;
            owner_d = gnt;
            addr_d = gnt ? m1_addr_i : m0_addr_i;
            we_d = gnt ? m1_we_i : m0_we_i;
            wdata_d = gnt ? m1_wdata_i : m0_wdata_i;
         end
         ISSUE: state_d = RESP;
         RESP: begin
            state_d = IDLE;
            ack_d[owner_q] = 1'b1;
            err_d[owner_q] = mis;
            if (!we_q && !mis) rdata_d[owner_q] = mem_rdata_i;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         owner_q <= M_CPU;
         addr_q <= '0;
         we_q <= 1'b0;
         wdata_q <= '0;
         ack_q <= '0;
         err_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q <= addr_d;
         we_q <= we_d;
         wdata_q <= wdata_d;
         ack_q <= ack_d;
         err_q <= err_d;
         rdata_q <= rdata_d;
      end

   // strobe is decoded from state so reset removes it without waiting for a clock
   assign mem_we_o = (state_q == ISSUE) && we_q && !mis;
   assign mem_addr_o = addr_q;
   assign mem_wdata_o = wdata_q;
   assign owner_o = owner_q;
   assign m0_ack_o = ack_q[M_CPU];
   assign m0_err_o = err_q[M_CPU];
   assign m0_rdata_o = rdata_q[M_CPU];
   assign m1_ack_o = ack_q[M_LOADER];
   assign m1_err_o = err_q[M_LOADER];
   assign m1_rdata_o = rdata_q[M_LOADER];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: per-cycle vector table plus reset-abort sequence against a small sync RAM model
module tb_mem_bus_arbiter;
   logic clk, rst_n;
   logic m0_req, m0_we, m0_lock, m0_ack, m0_err;
   logic m1_req, m1_we, m1_lock, m1_ack, m1_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic mem_we, owner;
   int total = 0, bad = 0;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_wdata_i(m0_wdata), .m0_lock_i(m0_lock),
      .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_wdata_i(m1_wdata), .m1_lock_i(m1_lock),
      .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .owner_o(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] DB = 32'hDEADBEEF, M9 = 32'h24242424, M40 = 32'h40404040, A5 = 32'hA5A5A5A5;
   logic [31:0] mem [64];
   bit pre = 1'b0;
   always @(posedge clk) begin
      if (!pre) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[1] <= 32'h11111111;
         mem[4] <= DB;
         mem[9] <= M9;
         mem[16] <= M40;
         pre <= 1'b1;
      end else begin
         if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[7:2]];
      end
   end

   typedef struct {
      logic [2:0]  c0;
      logic [31:0] a0, d0;
      logic [2:0]  c1;
      logic [31:0] a1, d1;
      logic [5:0]  f;
      logic [31:0] ea, r0, r1;
   } vec_t;
   vec_t tv[$];

   localparam logic [2:0] NO = 3'b000, RD = 3'b100, WR = 3'b110, RL = 3'b101;

   function automatic vec_t v(input logic [2:0] c0, input logic [31:0] a0, d0,
                              input logic [2:0] c1, input logic [31:0] a1, d1,
                              input logic [5:0] f, input logic [31:0] ea, r0, r1);
      vec_t x;
      x.c0 = c0; x.a0 = a0; x.d0 = d0; x.c1 = c1; x.a1 = a1; x.d1 = d1;
      x.f = f; x.ea = ea; x.r0 = r0; x.r1 = r1;
      return x;
   endfunction

   task automatic drive(input vec_t x);
      {m0_req, m0_we, m0_lock} = x.c0;
      m0_addr = x.a0;
      m0_wdata = x.d0;
      {m1_req, m1_we, m1_lock} = x.c1;
      m1_addr = x.a1;
      m1_wdata = x.d1;
   endtask

   task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", n, act, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(v(NO, 0, 0, NO, 0, 0, 0, 0, 0, 0));
      // f = {m0_ack, m0_err, m1_ack, m1_err, mem_we, owner}
      // both request from reset: strict alternation M0 write, M1 read
      for (int k = 0; k < 2; k++) begin
         tv.push_back(v(WR, 'h20, 1, RD, 'h24, 0, 6'b000010, 'h20, 0, k ? M9 : 0));
         tv.push_back(v(WR, 'h20, 1, RD, 'h24, 0, 6'b000000, 'h20, 0, k ? M9 : 0));
         tv.push_back(v(WR, 'h20, 1, RD, 'h24, 0, 6'b100000, 'h20, 0, k ? M9 : 0));
         if (k == 0) begin
            tv.push_back(v(WR, 'h20, 1, RD, 'h24, 0, 6'b000001, 'h24, 0, 0));
            tv.push_back(v(WR, 'h20, 1, RD, 'h24, 0, 6'b000001, 'h24, 0, 0));
            tv.push_back(v(WR, 'h20, 1, RD, 'h24, 0, 6'b001001, 'h24, 0, M9));
         end
      end
      tv.push_back(v(NO, 0, 0, NO, 0, 0, 6'b000000, 'h20, 0, M9));
      // M0 alone reads 0x10
      tv.push_back(v(RD, 'h10, 0, NO, 0, 0, 6'b000000, 'h10, 0, M9));
      tv.push_back(v(RD, 'h10, 0, NO, 0, 0, 6'b000000, 'h10, 0, M9));
      tv.push_back(v(RD, 'h10, 0, NO, 0, 0, 6'b100000, 'h10, DB, M9));
      tv.push_back(v(NO, 0, 0, NO, 0, 0, 6'b000000, 'h10, DB, M9));
      // read-after-write through the arbiter
      tv.push_back(v(WR, 'h30, A5, NO, 0, 0, 6'b000010, 'h30, DB, M9));
      tv.push_back(v(WR, 'h30, A5, NO, 0, 0, 6'b000000, 'h30, DB, M9));
      tv.push_back(v(WR, 'h30, A5, NO, 0, 0, 6'b100000, 'h30, DB, M9));
      tv.push_back(v(NO, 0, 0, NO, 0, 0, 6'b000000, 'h30, DB, M9));
      tv.push_back(v(RD, 'h30, 0, NO, 0, 0, 6'b000000, 'h30, DB, M9));
      tv.push_back(v(RD, 'h30, 0, NO, 0, 0, 6'b000000, 'h30, DB, M9));
      tv.push_back(v(RD, 'h30, 0, NO, 0, 0, 6'b100000, 'h30, A5, M9));
      tv.push_back(v(NO, 0, 0, NO, 0, 0, 6'b000000, 'h30, A5, M9));
      // misaligned write: error, no strobe
      tv.push_back(v(WR, 'h6, 32'hFFFFFFFF, NO, 0, 0, 6'b000000, 'h6, A5, M9));
      tv.push_back(v(WR, 'h6, 32'hFFFFFFFF, NO, 0, 0, 6'b000000, 'h6, A5, M9));
      tv.push_back(v(WR, 'h6, 32'hFFFFFFFF, NO, 0, 0, 6'b110000, 'h6, A5, M9));
      tv.push_back(v(NO, 0, 0, NO, 0, 0, 6'b000000, 'h6, A5, M9));
      // M1 locked for three reads while M0 requests continuously
      for (int k = 0; k < 3; k++) begin
         tv.push_back(v(RD, 'h10, 0, RL, 'h40, 0, 6'b000001, 'h40, A5, k ? M40 : M9));
         tv.push_back(v(RD, 'h10, 0, RL, 'h40, 0, 6'b000001, 'h40, A5, k ? M40 : M9));
         tv.push_back(v(RD, 'h10, 0, RL, 'h40, 0, 6'b001001, 'h40, A5, M40));
      end
      tv.push_back(v(RD, 'h10, 0, NO, 0, 0, 6'b000000, 'h10, A5, M40));
      tv.push_back(v(RD, 'h10, 0, NO, 0, 0, 6'b000000, 'h10, A5, M40));
      tv.push_back(v(RD, 'h10, 0, NO, 0, 0, 6'b100000, 'h10, DB, M40));
      tv.push_back(v(NO, 0, 0, NO, 0, 0, 6'b000000, 'h10, DB, M40));

      repeat (3) @(posedge clk);
      #1 chk("reset_state", {m0_ack, m0_err, m1_ack, m1_err, mem_we, owner, mem_addr, mem_wdata, m0_rdata, m1_rdata}, '0);
      @(negedge clk) rst_n = 1'b1;
      foreach (tv[i]) begin
         drive(tv[i]);
         @(posedge clk);
         #1 chk($sformatf("vec%0d", i),
                {m0_ack, m0_err, m1_ack, m1_err, mem_we, owner, mem_addr, m0_rdata, m1_rdata},
                {tv[i].f, tv[i].ea, tv[i].r0, tv[i].r1});
      end
      chk("mem_misaligned_untouched", mem[1], 32'h11111111);
      chk("mem_write_0x20", mem[8], 32'h1);
      chk("mem_write_0x30", mem[12], A5);

      // reset during ISSUE of an M1 write
      drive(v(NO, 0, 0, WR, 'h44, 32'h99, 0, 0, 0, 0));
      @(posedge clk);
      #1 chk("rst_issue_pre", {mem_we, owner}, 2'b11);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_drop", {mem_we, owner, m1_ack, mem_addr}, '0);
      drive(v(NO, 0, 0, NO, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1 chk("rst_no_ack", {m1_ack, m1_err, mem_we, m1_rdata}, '0);
      @(negedge clk) rst_n = 1'b1;
      drive(v(RD, 'h10, 0, RD, 'h24, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 chk("rst_rr_first_m0", {owner, mem_addr}, {1'b0, 32'h10});
      repeat (2) @(posedge clk);
      #1 chk("rst_rr_ack", {m0_ack, m1_ack, m0_rdata}, {2'b10, DB});
      drive(v(NO, 0, 0, NO, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1 chk("rst_write_aborted", mem[17], 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
